d_flip_flop: RTL and testbench
==============================

// Module: d_flip_flop
//
// PURPOSE
//   Edge-triggered D-type storage register with true and complemented outputs.
//   Samples D on every rising clk edge and presents the value on Q, with Q_n = ~Q.
//   Basic state element for the datapath (pipeline registers, PC, flags).
//   Default build is a 1-bit flop; WIDTH widens it to a register bank.
//
// PARAMETERS
//   WIDTH        1     data width in bits of D, Q and Q_n
//   RESET_VALUE  0     value loaded into Q on reset (WIDTH bits); Q_n gets ~RESET_VALUE
//
// PORTS
//   clk    in   1      clock; all state changes on its rising edge
//   reset  in   1      synchronous, active-high reset
//   D      in   WIDTH  data input, sampled at rising clk edge
//   Q      out  WIDTH  registered output
//   Q_n    out  WIDTH  bitwise complement of Q
//   ce     in   1      clock enable; port exists only when DFLIPFLOP_CE_EN is defined
//
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high. No asynchronous set/clear.
//   - Rising clk edge with reset=1: Q <= RESET_VALUE, Q_n <= ~RESET_VALUE.
//     Reset overrides D (and ce).
//   - Rising clk edge with reset=0: Q <= D, Q_n <= ~D.
//   - Latency: D at edge N is visible on Q immediately after edge N. Changes of D between
//     edges have no effect on Q.
//   - Reset asserted or deasserted between edges does nothing until the next rising edge.
//   - Reset held for multiple cycles: Q stays RESET_VALUE.
//   - Release: the first edge with reset=0 loads D.
//   - Q_n == ~Q at all times after the first active edge; the pair never shows equal bits.
//     Q_n is derived from the same storage as Q, not from a second flop that could diverge.
//   - Power-up before the first edge: Q/Q_n are undefined (X in simulation).
//     The system applies reset to define state.
//   - Falling clk edges cause no state change.
//   - Each bit operates independently; no arithmetic, no width conversion.
//
// CONFIGURATION
//   - DFLIPFLOP_CE_EN defined:
//     - Adds input ce.
//     - Edge with reset=0, ce=0: Q holds its value.
//     - Edge with reset=0, ce=1: Q <= D.
//     - reset=1 clears regardless of ce.
//   - Not defined: no ce port; the register loads D on every non-reset edge.
//
// TESTING
//   1. reset=1 across one rising edge, D=1 -> Q=0, Q_n=1 (RESET_VALUE=0).
//   2. reset=0; D=1 before edge -> Q=1, Q_n=0. Then D=0 -> next edge gives Q=0, Q_n=1.
//   3. D toggled 0->1->0 within one clock period (between edges) -> Q unchanged until the
//      edge, then equals D at that edge.
//   4. Q=1; reset=1 asserted mid-cycle -> Q stays 1 until the next rising edge, then Q=0.
//      Deassert reset with D=1 -> Q=1 after the following edge.
//   5. Random D stream over 20 edges with reset=0 -> Q(n)=D sampled at edge n, and
//      Q_n==~Q checked every cycle.
//   6. DFLIPFLOP_CE_EN defined: ce=0, D=1, Q=0 -> Q stays 0. ce=1 -> Q=1.
//      ce=0 with reset=1 -> Q=0.

Source files
------------

// File: rtl/d_flip_flop.sv
// Edge-triggered D register with true and complemented outputs.
// Optional clock enable port when DFLIPFLOP_CE_EN is defined.
module d_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
`ifdef DFLIPFLOP_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n
);

  logic [WIDTH-1:0] q_r;

`ifdef DFLIPFLOP_CE_EN
  always_ff @(posedge clk) begin
    if (reset)
      q_r <= RESET_VALUE;
    else if (ce)
      q_r <= D;
  end
`else
  always_ff @(posedge clk) begin
    if (reset)
      q_r <= RESET_VALUE;
    else
      q_r <= D;
  end
`endif

  // Q_n shares storage with Q so the pair can never diverge
  assign Q   = q_r;
  assign Q_n = ~q_r;

endmodule

// File: tb/tb_d_flip_flop.sv
// Self-checking bench for d_flip_flop: 1-bit default and 8-bit instance,
// checked against a per-edge behavioural model.
module tb_d_flip_flop;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk;
  logic       reset;
  logic       ce;
  logic       d1;
  logic       q1;
  logic       q1n;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [7:0] q8n;

  logic       m1;
  logic [7:0] m8;

  int checks;
  int fails;

  d_flip_flop u_narrow (
    .clk   (clk),
    .reset (reset),
`ifdef DFLIPFLOP_CE_EN
    .ce    (ce),
`endif
    .D     (d1),
    .Q     (q1),
    .Q_n   (q1n)
  );

  d_flip_flop #(
    .WIDTH       (8),
    .RESET_VALUE (RV8)
  ) u_wide (
    .clk   (clk),
    .reset (reset),
`ifdef DFLIPFLOP_CE_EN
    .ce    (ce),
`endif
    .D     (d8),
    .Q     (q8),
    .Q_n   (q8n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: what the register should hold after the coming rising edge
  task automatic tick();
    logic en;
`ifdef DFLIPFLOP_CE_EN
    en = ce;
`else
    en = 1'b1;
`endif
    if (reset) begin
      m1 = 1'b0;
      m8 = RV8;
    end else if (en) begin
      m1 = d1;
      m8 = d8;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name);
    checks++;
    if ({q1, q1n} !== {m1, ~m1}) begin
      fails++;
      $display("FAIL %s narrow: Q/Q_n=%b/%b expected %b/%b",
               name, q1, q1n, m1, ~m1);
    end
    checks++;
    if ({q8, q8n} !== {m8, ~m8}) begin
      fails++;
      $display("FAIL %s wide: Q/Q_n=%h/%h expected %h/%h",
               name, q8, q8n, m8, ~m8);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    d1 = 1'b1;
    d8 = 8'h3C;
    tick();
    cmp("reset_first");
    for (int i = 0; i < 3; i++) begin
      d1 = ~d1;
      d8 = 8'($urandom);
      tick();
      cmp("reset_hold");
    end
  endtask

  task automatic test_load();
    reset = 1'b0;
    d1 = 1'b1;
    d8 = 8'h5A;
    tick();
    cmp("load_one");
    d1 = 1'b0;
    d8 = 8'hC3;
    tick();
    cmp("load_zero");
  endtask

  task automatic test_between_edges();
    d1 = 1'b0;
    d8 = 8'h00;
    #2;
    d1 = 1'b1;
    d8 = 8'hFF;
    #2;
    cmp("mid_high");
    d1 = 1'b0;
    d8 = 8'h81;
    #2;
    cmp("mid_after_negedge");
    tick();
    cmp("edge_sample_0");
    d1 = 1'b0;
    #2;
    d1 = 1'b1;
    d8 = 8'h7E;
    tick();
    cmp("edge_sample_1");
  endtask

  task automatic test_reset_midcycle();
    d1 = 1'b1;
    d8 = 8'h12;
    tick();
    cmp("pre_reset");
    #2;
    reset = 1'b1;
    #1;
    cmp("reset_async_ignored");
    tick();
    cmp("reset_at_edge");
    #2;
    reset = 1'b0;
    d1 = 1'b1;
    d8 = 8'hEE;
    #1;
    cmp("release_wait");
    tick();
    cmp("release_load");
  endtask

  task automatic test_random();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      d1 = 1'($urandom);
      d8 = 8'($urandom);
      tick();
      cmp("random_stream");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      reset = ($urandom_range(0, 7) == 0);
`ifdef DFLIPFLOP_CE_EN
      ce = 1'($urandom);
`endif
      d1 = 1'($urandom);
      d8 = 8'($urandom);
      tick();
      cmp("random_mixed");
    end
    reset = 1'b0;
    ce = 1'b1;
  endtask

`ifdef DFLIPFLOP_CE_EN
  task automatic test_ce();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ce = 1'b0;
    d1 = 1'b1;
    d8 = 8'h00;
    tick();
    cmp("ce_hold");
    ce = 1'b1;
    tick();
    cmp("ce_load");
    ce = 1'b0;
    reset = 1'b1;
    tick();
    cmp("ce_reset");
    reset = 1'b0;
    ce = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    fails = 0;
    reset = 1'b0;
    ce = 1'b1;
    d1 = 1'b0;
    d8 = 8'h00;
    m1 = 1'bx;
    m8 = 'x;
    #2;
    test_reset();
    test_load();
    test_between_edges();
    test_reset_midcycle();
    test_random();
    test_back_to_back();
`ifdef DFLIPFLOP_CE_EN
    test_ce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
